fp_add_pipe: RTL and testbench

Parametrised, pipelined IEEE-754-style floating-point adder/subtractor: the successor to the fixed 32-bit adder in the matrix-multiplier datapath. Configurable exponent and mantissa widths, add or subtract per operation, round-to-nearest-even, and a valid/ready handshake on both sides so the accumulator stage can stall it. Fixed latency of four accepted cycles; one result per cycle when not stalled.

---
 rtl/fp_add_pipe_if.sv | 39 +++
 rtl/fp_add_pipe.sv | 263 ++++++++++++++++++++++++++
 tb/tb_fp_add_pipe.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fp_add_pipe_if.sv
// -----------------------------------------------------------------------------
// fp_add_pipe_if
// Operand/result handshake bundle for the pipelined floating-point adder.
//   i_a, i_b    operand words (sign | exponent | fraction), W = 1+EXP_W+MAN_W
//   i_sub       1: A-B, 0: A+B
//   i_vld/o_rdy operand handshake, transfer when both high
//   o_res       result word
//   o_res_vld/i_res_rdy  result handshake, transfer when both high
//   o_ovf       finite operands overflowed to infinity
//   o_inv       invalid operation (NaN operand or inf - inf)
// Modports: master = producer/consumer around the adder, slave = the adder.
// -----------------------------------------------------------------------------
interface fp_add_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) ();
  localparam int W = 1 + EXP_W + MAN_W;

  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_sub;
  logic         i_vld;
  logic         o_rdy;
  logic [W-1:0] o_res;
  logic         o_res_vld;
  logic         i_res_rdy;
  logic         o_ovf;
  logic         o_inv;

  modport master (
    output i_a, i_b, i_sub, i_vld, i_res_rdy,
    input  o_rdy, o_res, o_res_vld, o_ovf, o_inv
  );

  modport slave (
    input  i_a, i_b, i_sub, i_vld, i_res_rdy,
    output o_rdy, o_res, o_res_vld, o_ovf, o_inv
  );
endinterface

// File: rtl/fp_add_pipe.sv
// -----------------------------------------------------------------------------
// fp_add_pipe
// Pipelined IEEE-754-style adder/subtractor with configurable exponent and
// fraction widths, round-to-nearest-even and valid/ready on both sides.
// Operands are captured on acceptance, then pass unpack/align/add-normalise/
// round stages; a result is valid four accepted edges after its operands.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fp_add_pipe_if.slave (operands, result, handshakes, flags)
// Build option:
//   FP_ADD_DENORM_EN  defined: gradual underflow (subnormal in/out);
//                     undefined: subnormal inputs read as signed zero and
//                     results below normal range flush to signed zero.
// -----------------------------------------------------------------------------
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic          clk,
  input logic          rst_n,
  fp_add_pipe_if.slave bus
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int MW     = MAN_W + 4;            // hidden + fraction + G,R,S
  localparam int SH_MAX = MAN_W + 3;
  localparam int SHW    = $clog2(SH_MAX + 1);
  localparam int LZW    = $clog2(MW + 1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  // Whole pipeline moves together; it only freezes when a finished result
  // is waiting on downstream.
  logic en;
  assign en        = ~bus.o_res_vld | bus.i_res_rdy;
  assign bus.o_rdy = en;

  // ---------------- operand capture ----------------
  logic         v0, sub0;
  logic [W-1:0] a0, b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0 <= 1'b0; sub0 <= 1'b0; a0 <= '0; b0 <= '0;
    end else if (en) begin
      v0 <= bus.i_vld; sub0 <= bus.i_sub; a0 <= bus.i_a; b0 <= bus.i_b;
    end
  end

  // ---------------- stage 1: unpack, classify, swap ----------------
  logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
  logic [EXP_W-1:0] ea, eb, ea_e, eb_e, n1_el, n1_es, n1_diff;
  logic [MAN_W-1:0] fa, fb;
  logic [MAN_W:0]   ma, mb, n1_ml, n1_ms;
  logic             n1_sign, n1_sp, n1_inv;
  logic [W-1:0]     n1_spres;

  always_comb begin
    sa = a0[W-1];
    sb = b0[W-1] ^ sub0;
    ea = a0[W-2:MAN_W];
    eb = b0[W-2:MAN_W];
    fa = a0[MAN_W-1:0];
    fb = b0[MAN_W-1:0];
`ifdef FP_ADD_DENORM_EN
    ea_e   = (ea == '0) ? EXP_W'(1) : ea;
    eb_e   = (eb == '0) ? EXP_W'(1) : eb;
    ma     = {ea != '0, fa};
    mb     = {eb != '0, fb};
    a_zero = (ea == '0) && (fa == '0);
    b_zero = (eb == '0) && (fb == '0);
`else
    ea_e   = ea;
    eb_e   = eb;
    ma     = (ea == '0) ? '0 : {1'b1, fa};
    mb     = (eb == '0) ? '0 : {1'b1, fb};
    a_zero = (ea == '0);
    b_zero = (eb == '0);
`endif
    a_inf = (ea == EXP_ONES) && (fa == '0);
    b_inf = (eb == EXP_ONES) && (fb == '0);
    a_nan = (ea == EXP_ONES) && (fa != '0);
    b_nan = (eb == EXP_ONES) && (fb != '0);

    swap    = {eb_e, mb} > {ea_e, ma};
    n1_sign = swap ? sb : sa;
    n1_el   = swap ? eb_e : ea_e;
    n1_es   = swap ? ea_e : eb_e;
    n1_ml   = swap ? mb : ma;
    n1_ms   = swap ? ma : mb;
    n1_diff = n1_el - n1_es;

    // Special operands bypass the arithmetic with a ready-made answer.
    n1_sp    = 1'b1;
    n1_inv   = 1'b0;
    n1_spres = '0;
    if (a_nan || b_nan) begin
      n1_inv = 1'b1; n1_spres = QNAN;
    end else if (a_inf && b_inf) begin
      if (sa != sb) begin
        n1_inv = 1'b1; n1_spres = QNAN;
      end else begin
        n1_spres = {sa, EXP_ONES, {MAN_W{1'b0}}};
      end
    end else if (a_inf) begin
      n1_spres = {sa, EXP_ONES, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      n1_spres = {sb, EXP_ONES, {MAN_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      n1_spres = {sa & sb, {(W-1){1'b0}}};
    end else begin
      n1_sp = 1'b0;
    end
  end

  logic             v1, sign1, effsub1, sp1, inv1;
  logic [EXP_W-1:0] el1, diff1;
  logic [MAN_W:0]   ml1, ms1;
  logic [W-1:0]     spres1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; sign1 <= 1'b0; effsub1 <= 1'b0; sp1 <= 1'b0; inv1 <= 1'b0;
      el1 <= '0; diff1 <= '0; ml1 <= '0; ms1 <= '0; spres1 <= '0;
    end else if (en) begin
      v1 <= v0; sign1 <= n1_sign; effsub1 <= sa ^ sb; sp1 <= n1_sp; inv1 <= n1_inv;
      el1 <= n1_el; diff1 <= n1_diff; ml1 <= n1_ml; ms1 <= n1_ms; spres1 <= n1_spres;
    end
  end

  // ---------------- stage 2: align smaller operand ----------------
  // Everything shifted past the sticky position is ORed into bit 0.
  logic [SHW-1:0] sh;
  logic [MW-1:0]  ext, mask, aligned;
  logic           sticky;

  always_comb begin
    sh      = (int'(diff1) > SH_MAX) ? SHW'(SH_MAX) : SHW'(diff1);
    ext     = {ms1, 3'b000};
    mask    = ~({MW{1'b1}} << sh);
    sticky  = |(ext & mask);
    aligned = (ext >> sh) | {{(MW-1){1'b0}}, sticky};
  end

  logic             v2, sign2, effsub2, sp2, inv2;
  logic [EXP_W-1:0] el2;
  logic [MW-1:0]    ml2, ms2;
  logic [W-1:0]     spres2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0; sign2 <= 1'b0; effsub2 <= 1'b0; sp2 <= 1'b0; inv2 <= 1'b0;
      el2 <= '0; ml2 <= '0; ms2 <= '0; spres2 <= '0;
    end else if (en) begin
      v2 <= v1; sign2 <= sign1; effsub2 <= effsub1; sp2 <= sp1; inv2 <= inv1;
      el2 <= el1; ml2 <= {ml1, 3'b000}; ms2 <= aligned; spres2 <= spres1;
    end
  end

  // ---------------- stage 3: add/sub, normalise ----------------
  logic [MW:0]      sum;
  logic [LZW-1:0]   lzc;
  int               el_i, lz_i;
  logic [MW-1:0]    n3_man;
  logic [EXP_W:0]   n3_exp;
  logic             n3_zero, n3_zsign;

  always_comb begin
    sum = effsub2 ? ({1'b0, ml2} - {1'b0, ms2}) : ({1'b0, ml2} + {1'b0, ms2});
    lzc = LZW'(MW);
    for (int i = 0; i < MW; i++) begin
      if (sum[i]) lzc = LZW'(MW - 1 - i);
    end
    el_i     = int'(el2);
    lz_i     = int'(lzc);
    n3_man   = '0;
    n3_exp   = '0;
    n3_zero  = 1'b0;
    n3_zsign = 1'b0;
    if (sum == '0) begin
      // exact cancellation always yields +0
      n3_zero = 1'b1;
    end else if (sum[MW]) begin
      n3_man = {sum[MW:2], sum[1] | sum[0]};
      n3_exp = (EXP_W+1)'(el_i + 1);
    end else if (el_i - lz_i >= 1) begin
      n3_man = sum[MW-1:0] << lzc;
      n3_exp = (EXP_W+1)'(el_i - lz_i);
    end else begin
`ifdef FP_ADD_DENORM_EN
      // stop at the minimum exponent, leaving a subnormal significand
      n3_man = sum[MW-1:0] << (el_i - 1);
      n3_exp = (EXP_W+1)'(1);
`else
      n3_zero  = 1'b1;
      n3_zsign = sign2;
`endif
    end
  end

  logic             v3, sign3, zero3, zsign3, sp3, inv3;
  logic [MW-1:0]    man3;
  logic [EXP_W:0]   exp3;
  logic [W-1:0]     spres3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3 <= 1'b0; sign3 <= 1'b0; zero3 <= 1'b0; zsign3 <= 1'b0; sp3 <= 1'b0;
      inv3 <= 1'b0; man3 <= '0; exp3 <= '0; spres3 <= '0;
    end else if (en) begin
      v3 <= v2; sign3 <= sign2; zero3 <= n3_zero; zsign3 <= n3_zsign; sp3 <= sp2;
      inv3 <= inv2; man3 <= n3_man; exp3 <= n3_exp; spres3 <= spres2;
    end
  end

  // ---------------- stage 4: round, pack, flags ----------------
  logic             up, hid, n_ovf, n_inv;
  logic [MAN_W+1:0] rnd;
  logic [MAN_W-1:0] frac;
  logic [EXP_W:0]   exp_r;
  logic [EXP_W-1:0] efield;
  logic [W-1:0]     n_res;

  always_comb begin
    up  = man3[2] & (man3[1] | man3[0] | man3[3]);
    rnd = {1'b0, man3[MW-1:3]} + {{(MAN_W+1){1'b0}}, up};
    if (rnd[MAN_W+1]) begin
      hid   = 1'b1;
      frac  = rnd[MAN_W:1];
      exp_r = exp3 + (EXP_W+1)'(1);
    end else begin
      hid   = rnd[MAN_W];
      frac  = rnd[MAN_W-1:0];
      exp_r = exp3;
    end
    // a clear hidden bit only survives for subnormal results
    efield = hid ? exp_r[EXP_W-1:0] : '0;
    n_ovf  = 1'b0;
    n_inv  = 1'b0;
    if (sp3) begin
      n_res = spres3;
      n_inv = inv3;
    end else if (zero3) begin
      n_res = {zsign3, {(W-1){1'b0}}};
    end else if (exp_r >= {1'b0, EXP_ONES}) begin
      n_res = {sign3, EXP_ONES, {MAN_W{1'b0}}};
      n_ovf = 1'b1;
    end else begin
      n_res = {sign3, efield, frac};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.o_res_vld <= 1'b0; bus.o_res <= '0; bus.o_ovf <= 1'b0; bus.o_inv <= 1'b0;
    end else if (en) begin
      bus.o_res_vld <= v3;
      if (v3) begin
        bus.o_res <= n_res; bus.o_ovf <= n_ovf; bus.o_inv <= n_inv;
      end
    end
  end
endmodule

// File: tb/tb_fp_add_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp_add_pipe
// Directed-vector bench for fp_add_pipe with single-precision defaults.
// Covers reset state, arithmetic, specials, overflow, cancellation, rounding
// ties, subnormals (expectation follows FP_ADD_DENORM_EN), a randomly stalled
// stream and reset in the middle of a stream.
// -----------------------------------------------------------------------------
module tb_fp_add_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_add_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  localparam int NVEC = 13;
  logic [31:0] vec_a   [NVEC];
  logic [31:0] vec_b   [NVEC];
  logic [31:0] vec_exp [NVEC];
  logic        vec_sub [NVEC];
  logic        vec_ovf [NVEC];
  logic        vec_inv [NVEC];

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic setVec(input int i, input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [31:0] r, input logic ovf, input logic inv);
    vec_a[i] = a; vec_b[i] = b; vec_sub[i] = sub;
    vec_exp[i] = r; vec_ovf[i] = ovf; vec_inv[i] = inv;
  endtask

  task automatic driveVec(input int i);
    bus.i_a = vec_a[i]; bus.i_b = vec_b[i]; bus.i_sub = vec_sub[i];
  endtask

  // One isolated operation: latency, result and flags.
  task automatic applyStimulus(input int i);
    int lat;
    @(negedge clk);
    driveVec(i);
    bus.i_vld = 1'b1;
    bus.i_res_rdy = 1'b1;
    @(posedge clk);
    #1 bus.i_vld = 1'b0;
    lat = 0;
    while (bus.o_res_vld !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
    checkOutput($sformatf("v%0d_res", i), bus.o_res, vec_exp[i]);
    checkOutput($sformatf("v%0d_ovf", i), 32'(bus.o_ovf), 32'(vec_ovf[i]));
    checkOutput($sformatf("v%0d_inv", i), 32'(bus.o_inv), 32'(vec_inv[i]));
    @(posedge clk);
    #1;
  endtask

  // Eight pairs back-to-back with random downstream stalls.
  task automatic streamTest();
    int in_idx = 0;
    int out_idx = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic fire_in, fire_out, exp_rdy;
    logic [31:0] held = '0;
    while (out_idx < 8 && cyc < 300) begin
      @(negedge clk);
      bus.i_res_rdy = 1'($urandom_range(0, 1));
      if (in_idx < 8) begin
        driveVec(in_idx);
        bus.i_vld = 1'b1;
      end else begin
        bus.i_vld = 1'b0;
      end
      #1;
      exp_rdy = ~(bus.o_res_vld & ~bus.i_res_rdy);
      checkOutput("rdy_rule", 32'(bus.o_rdy), 32'(exp_rdy));
      if (stalled) begin
        checkOutput("stall_vld", 32'(bus.o_res_vld), 32'd1);
        checkOutput("stall_hold", bus.o_res, held);
      end
      fire_in  = bus.i_vld & bus.o_rdy;
      fire_out = bus.o_res_vld & bus.i_res_rdy;
      if (fire_out) checkOutput($sformatf("stream%0d", out_idx), bus.o_res, vec_exp[out_idx]);
      stalled = bus.o_res_vld & ~bus.i_res_rdy;
      held    = bus.o_res;
      @(posedge clk);
      if (fire_in) in_idx++;
      if (fire_out) out_idx++;
      cyc++;
    end
    checkOutput("stream_count", 32'(out_idx), 32'd8);
    @(negedge clk);
    bus.i_vld = 1'b0;
    bus.i_res_rdy = 1'b1;
  endtask

  // Reset while results are in flight and one is on the output.
  task automatic resetTest();
    int stale = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      driveVec(k);
      bus.i_vld = 1'b1;
      bus.i_res_rdy = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    bus.i_vld = 1'b0;
    checkOutput("pre_reset_vld", 32'(bus.o_res_vld), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_vld", 32'(bus.o_res_vld), 32'd0);
    checkOutput("midrst_res", bus.o_res, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.o_res_vld === 1'b1) stale++;
    end
    checkOutput("no_stale", 32'(stale), 32'd0);
    checkOutput("post_rst_rdy", 32'(bus.o_rdy), 32'd1);
  endtask

  initial begin
    setVec(0,  32'h40000000, 32'h40400000, 1'b0, 32'h40A00000, 1'b0, 1'b0);
    setVec(1,  32'hC0000000, 32'h40400000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
    setVec(2,  32'h3089705F, 32'hC12E38E4, 1'b0, 32'hC12E38E4, 1'b0, 1'b0);
    setVec(3,  32'h7F800000, 32'hC0000000, 1'b0, 32'h7F800000, 1'b0, 1'b0);
    setVec(4,  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b1);
    setVec(5,  32'h7FC00000, 32'h40000000, 1'b0, 32'h7FC00000, 1'b0, 1'b1);
    setVec(6,  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0);
    setVec(7,  32'h42F6E979, 32'h42F6E979, 1'b1, 32'h00000000, 1'b0, 1'b0);
    setVec(8,  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
    setVec(9,  32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b0);
`ifdef FP_ADD_DENORM_EN
    setVec(10, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0);
`else
    setVec(10, 32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 1'b0, 1'b0);
`endif
    setVec(11, 32'h40400000, 32'h40000000, 1'b1, 32'h3F800000, 1'b0, 1'b0);
    setVec(12, 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0);

    bus.i_a = '0;
    bus.i_b = '0;
    bus.i_sub = 1'b0;
    bus.i_vld = 1'b0;
    bus.i_res_rdy = 1'b1;
    rst_n = 1'b0;
    #12;
    checkOutput("rst_vld", 32'(bus.o_res_vld), 32'd0);
    checkOutput("rst_res", bus.o_res, 32'd0);
    checkOutput("rst_ovf", 32'(bus.o_ovf), 32'd0);
    checkOutput("rst_inv", 32'(bus.o_inv), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("idle_rdy", 32'(bus.o_rdy), 32'd1);

    for (int i = 0; i < NVEC; i++) applyStimulus(i);
    streamTest();
    resetTest();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
